// File: rtl/approx_max_pkg.sv
// Shared types and helpers for the approximate streaming max block.
// Used by approx_max_cmp and approx_max_stream.
package approx_max_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned KEY_W     = 32;

  // Zero the low 'trunc' bits of a value; callers keep trunc below their data width.
  function automatic logic [KEY_W-1:0] trunc_key(input logic [KEY_W-1:0] value,
                                                 input int unsigned      trunc);
    logic [KEY_W-1:0] mask;
    mask = {KEY_W{1'b1}} << trunc;
    return value & mask;
  endfunction

endpackage

// File: rtl/approx_max_cmp.sv
// Combinational truncated comparator: o_gt = key(i_new) > key(i_old).
// The truncation level is clamped to DATA_W-1.
module approx_max_cmp
  import approx_max_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TRUNC_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  i_new,
  input  logic [DATA_W-1:0]  i_old,
  input  logic [TRUNC_W-1:0] i_trunc,
  output logic               o_gt
);

  logic [TRUNC_W-1:0] w_trunc;
  logic [KEY_W-1:0]   w_key_new;
  logic [KEY_W-1:0]   w_key_old;

  always_comb begin
    w_trunc = i_trunc;
    if (32'(i_trunc) > (DATA_W - 1)) begin
      w_trunc = TRUNC_W'(DATA_W - 1);
    end
  end

  assign w_key_new = trunc_key(KEY_W'(i_new), 32'(w_trunc));
  assign w_key_old = trunc_key(KEY_W'(i_old), 32'(w_trunc));
  assign o_gt      = (w_key_new > w_key_old);

endmodule

// File: rtl/approx_max_stream.sv
// Streaming frame reducer: max (truncated compare) and its beat index per FRAME_LEN samples.
// Optional APPROX_MAX_ERR_STAT_EN adds an exact-max shadow with o_out_err / o_err_cnt.
module approx_max_stream
  import approx_max_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN),
  parameter int unsigned TRUNC_W   = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [TRUNC_W-1:0] i_cfg_trunc,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [DATA_W-1:0]  o_out_max,
  output logic [IDX_W-1:0]   o_out_idx
`ifdef APPROX_MAX_ERR_STAT_EN
  ,
  output logic               o_out_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

  state_e             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [TRUNC_W-1:0] r_trunc;
  logic [DATA_W-1:0]  r_win_max;
  logic [IDX_W-1:0]   r_win_idx;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_max;
  logic [IDX_W-1:0]   r_out_idx;

  logic               w_accept;
  logic               w_start;
  logic               w_last;
  logic               w_gt;
  logic [DATA_W-1:0]  w_fin_max;
  logic [IDX_W-1:0]   w_fin_idx;

  assign o_in_ready = (r_state == StHold) ? i_out_ready : 1'b1;
  assign w_accept   = i_in_valid && o_in_ready;
  // A beat accepted outside ACCUM always opens a frame (IDLE, or HOLD during handoff).
  assign w_start    = w_accept && (r_state != StAccum);
  assign w_last     = (r_cnt == IDX_W'(FRAME_LEN - 1));

  approx_max_cmp #(
    .DATA_W  (DATA_W),
    .TRUNC_W (TRUNC_W)
  ) u_cmp (
    .i_new   (i_in_data),
    .i_old   (r_win_max),
    .i_trunc (r_trunc),
    .o_gt    (w_gt)
  );

  assign w_fin_max = w_gt ? i_in_data : r_win_max;
  assign w_fin_idx = w_gt ? r_cnt : r_win_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_trunc     <= '0;
      r_win_max   <= '0;
      r_win_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StAccum: begin
          if (w_accept) begin
            r_win_max <= w_fin_max;
            r_win_idx <= w_fin_idx;
            r_cnt     <= r_cnt + 1'b1;
            if (w_last) begin
              r_state     <= StHold;
              r_out_valid <= 1'b1;
              r_out_max   <= w_fin_max;
              r_out_idx   <= w_fin_idx;
              r_cnt       <= '0;
            end
          end
        end
        StHold: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_start) begin
        r_state   <= StAccum;
        r_trunc   <= i_cfg_trunc;
        r_win_max <= i_in_data;
        r_win_idx <= '0;
        r_cnt     <= IDX_W'(1);
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_max   = r_out_max;
  assign o_out_idx   = r_out_idx;

`ifdef APPROX_MAX_ERR_STAT_EN
  logic [DATA_W-1:0]    r_ex_max;
  logic                 r_out_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_ex_gt;
  logic [DATA_W-1:0]    w_fin_ex;

  approx_max_cmp #(
    .DATA_W  (DATA_W),
    .TRUNC_W (TRUNC_W)
  ) u_cmp_exact (
    .i_new   (i_in_data),
    .i_old   (r_ex_max),
    .i_trunc ('0),
    .o_gt    (w_ex_gt)
  );

  assign w_fin_ex = w_ex_gt ? i_in_data : r_ex_max;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_max  <= '0;
      r_out_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_start) begin
        r_ex_max <= i_in_data;
      end else if ((r_state == StAccum) && w_accept) begin
        r_ex_max <= w_fin_ex;
        if (w_last) begin
          r_out_err <= (w_fin_max != w_fin_ex);
        end
      end
      if (r_out_valid && i_out_ready && r_out_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_out_err = r_out_err;
  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/approx_max_stream.md
Name: approx_max_stream

Overview:
- Streaming, parametrised successor to the fixed 7-input factored approximate max block.
- Reduces each frame of FRAME_LEN unsigned DATA_W-bit samples to one max value plus the index where it occurred.
- Comparisons use runtime-selectable LSB truncation, so accuracy can be traded for comparator activity.
- Sits between a sample source and the error-evaluation / downstream consumer, with valid/ready on both sides.

Parameters:
- DATA_W, 8: sample width in bits; must be >= 2.
- FRAME_LEN, 16: samples per frame; must be >= 2.
- IDX_W, $clog2(FRAME_LEN): width of the index and beat counter (derived).
- TRUNC_W, $clog2(DATA_W): width of the truncation-level control (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_trunc  in  TRUNC_W  number of LSBs ignored in comparisons; sampled on the first beat of each frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  unsigned input sample.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts the result.
- out_max  out  DATA_W  exact (untruncated) value of the winning sample.
- out_idx  out  IDX_W  beat index of the winner within the frame (0-based).

Behaviour:
- Reset: synchronous and active-high; rst is sampled on rising clk and overrides every other input in that cycle.
  - Reset values: state=IDLE, beat counter=0, out_valid=0, out_max=0, out_idx=0, trunc register=0, in_ready=1 on the first cycle after reset.
  - rst mid-frame or during HOLD discards the partial or pending result with no output.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Key used for comparison: key(x) = x with its low trunc bits forced to 0, where trunc = min(cfg_trunc, DATA_W-1).
- IDLE:
  - in_ready=1.
  - On an accepted beat: latch trunc from cfg_trunc; winner value = in_data; winner index = 0; counter = 1; go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On an accepted beat: if key(in_data) > key(winner), replace the winner value and set winner index = counter.
  - Ties keep the earlier sample (strict greater-than).
  - Counter increments on each accepted beat.
  - When the beat with counter == FRAME_LEN-1 is accepted, go to HOLD.
- HOLD:
  - out_valid=1; out_max and out_idx are stable while out_valid && !out_ready.
  - in_ready = out_ready. This is a combinational pass-through and the only in_ready dependency on an output-side input.
  - On out_valid && out_ready with no accepted input beat: go to IDLE.
  - On out_valid && out_ready with an accepted input beat in the same cycle: that beat opens a new frame exactly as in IDLE (trunc relatched, counter=1), and the state goes to ACCUM.
- Latency:
  - out_valid rises on the clock edge that accepts the last beat (visible the following cycle).
  - Minimum frame period is FRAME_LEN cycles with no bubbles.
- in_valid gaps in ACCUM are legal; the counter holds.
- cfg_trunc changes mid-frame have no effect until the next frame start.
- out_max/out_idx hold their last value in IDLE/ACCUM; out_valid=0 there.

Optional Feature:
- Macro: APPROX_MAX_ERR_STAT_EN.
- When defined:
  - A parallel exact-max register (untruncated, strict >, earliest tie) is kept.
  - Added outputs:
    - out_err (1 bit): out_max != exact max, valid with out_valid.
    - err_cnt (16 bits): saturating count of handed-off frames with out_err=1; increments on handshake; reset to 0 by rst.
- When undefined: these ports and registers are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package approx_max_pkg holds:
  - state enum (IDLE, ACCUM, HOLD);
  - function trunc_key(value, trunc);
  - ERR_CNT_W=16 constant.
- One sub-module, approx_max_cmp: a combinational truncated comparator returning "new greater than old".
  - Reused for the exact path with trunc=0.

Test Plan:
1. DATA_W=8, FRAME_LEN=4, trunc=0; input 3,9,9,2 with in_valid held, out_ready=1 -> out_max=9, out_idx=1, out_valid exactly 1 cycle, in_ready continuous.
2. trunc=2; input 0x10,0x13,0x12,0x05 -> all keys equal 0x10 among the first three -> out_max=0x10, out_idx=0; with ERR_STAT, out_err=1 and err_cnt=1.
3. out_ready=0 for 5 cycles after frame end -> out_valid and outputs stable, in_ready=0; then out_ready=1 with in_valid=1, data=7 -> handoff and new frame start in the same cycle, counter=1.
4. Random in_valid bubbles (about 50%) over 3 frames -> results match the reference model, each out_idx counts accepted beats only.
5. Assert rst after 2 beats of a frame -> no output, out_valid=0, next full frame produces a correct result from beat 0.
6. cfg_trunc changed from 0 to 3 mid-frame -> current frame uses 0; next frame uses 3.
